// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one block-drawing datapath among up to 4 requesters.
// Optional BUSY watchdog abort is enabled by defining DRAW_ARBITER_TIMEOUT_EN.
module draw_arbiter #(
  parameter int NREQ     = 4,
  parameter int LINE_W   = 3,
  parameter int COLOUR_W = 3,
  parameter int TIMEOUT  = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LINE_W-1:0]   req_line_id,
  input  logic [NREQ*COLOUR_W-1:0] req_colour,
  output logic [NREQ-1:0]          ack,
  output logic                     draw_go,
  output logic [LINE_W-1:0]        draw_line_id,
  output logic [COLOUR_W-1:0]      draw_colour,
  input  logic                     draw_done,
  output logic [1:0]               grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                to_q, to_d;
  logic                expire;

  logic [LINE_W-1:0]   line_arr   [NREQ];
  logic [COLOUR_W-1:0] colour_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign line_arr[gi]   = req_line_id[gi*LINE_W +: LINE_W];
      assign colour_arr[gi] = req_colour[gi*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  generate
    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2 || TIMEOUT > 8192) begin : g_param_check
      $error("draw_arbiter: NREQ must be 2..4 and TIMEOUT 2..8192");
    end
  endgenerate

  // Padding to four bits lets the search index any slot without range issues.
  logic [3:0] req_pad;
  logic [1:0] winner;
  logic       any_req;
  int         idx;

  assign req_pad = 4'(req);

  // Walk offsets from farthest to nearest so the slot closest after the last
  // grant is the one left standing.
  always_comb begin
    winner  = grant_q;
    any_req = 1'b0;
    idx     = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(grant_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_pad[idx[1:0]]) begin
        winner  = idx[1:0];
        any_req = 1'b1;
      end
    end
  end

`ifdef DRAW_ARBITER_TIMEOUT_EN
  logic [12:0] wd_q, wd_d;

  assign wd_d   = (state_q == BUSY) ? wd_q + 13'd1 : 13'd0;
  assign expire = (wd_q == 13'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) wd_q <= 13'd0;
    else       wd_q <= wd_d;
  end

  assign timeout_err = (state_q == ACK) && to_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    line_d   = line_q;
    colour_d = colour_q;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = BUSY;
          grant_d  = winner;
          line_d   = line_arr[winner];
          colour_d = colour_arr[winner];
        end
      end
      BUSY: begin
        // A completion in the expiry cycle still counts as a normal finish.
        if (draw_done) begin
          state_d = ACK;
        end else if (expire) begin
          state_d = ACK;
          to_d    = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'(NREQ - 1);
      line_q   <= '0;
      colour_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      line_q   <= line_d;
      colour_q <= colour_d;
      to_q     <= to_d;
    end
  end

  assign draw_go      = (state_q == BUSY);
  assign busy         = (state_q != IDLE);
  assign ack          = (state_q == ACK) ? (NREQ'(1) << grant_q) : '0;
  assign grant_id     = grant_q;
  assign draw_line_id = line_q;
  assign draw_colour  = colour_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized bench for draw_arbiter against a transaction-level round-robin model.
module tb_draw_arbiter;
  localparam int NREQ = 4;
  localparam int LW   = 3;
  localparam int CW   = 3;
  localparam int TMO  = 16;
  localparam int LIW  = NREQ * LW;
  localparam int CIW  = NREQ * CW;

  logic            clock = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [LIW-1:0]  req_line_id;
  logic [CIW-1:0]  req_colour;
  logic [NREQ-1:0] ack;
  logic            draw_go;
  logic [LW-1:0]   draw_line_id;
  logic [CW-1:0]   draw_colour;
  logic            draw_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  draw_arbiter #(.NREQ(NREQ), .LINE_W(LW), .COLOUR_W(CW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_line_id(req_line_id),
    .req_colour(req_colour), .ack(ack), .draw_go(draw_go),
    .draw_line_id(draw_line_id), .draw_colour(draw_colour),
    .draw_done(draw_done), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int last_g;
  int n_draw = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first requester strictly after the previous grant, wrapping.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
    for (int off = 1; off <= NREQ; off++)
      if (m[(last + off) % NREQ]) return (last + off) % NREQ;
    return -1;
  endfunction

  // Entered at a negedge with the DUT idle; leaves at a negedge with it idle.
  task automatic run_draw(input logic [NREQ-1:0] mask, input logic [LIW-1:0] lines,
                          input logic [CIW-1:0] cols, input int dly, input bit scramble);
    int w;
    logic [LW-1:0] el;
    logic [CW-1:0] ec;
    req = mask; req_line_id = lines; req_colour = cols; draw_done = 1'b0;
    w  = rr_pick(last_g, mask);
    el = lines[w*LW +: LW];
    ec = cols[w*CW +: CW];
    @(negedge clock);
    chk("go_start", 32'(draw_go), 1);
    chk("grant", 32'(grant_id), w);
    chk("line", 32'(draw_line_id), 32'(el));
    chk("colour", 32'(draw_colour), 32'(ec));
    chk("busy_start", 32'(busy), 1);
    chk("ack_busy", 32'(ack), 0);
    for (int i = 0; i < dly; i++) begin
      if (scramble) begin
        req = NREQ'($urandom); req_line_id = LIW'($urandom); req_colour = CIW'($urandom);
      end
      @(negedge clock);
      chk("go_hold", 32'(draw_go), 1);
      chk("grant_hold", 32'(grant_id), w);
      chk("line_hold", 32'(draw_line_id), 32'(el));
      chk("colour_hold", 32'(draw_colour), 32'(ec));
    end
    draw_done = 1'b1;
    @(negedge clock);
    chk("ack", 32'(ack), 32'(1) << w);
    chk("go_ack", 32'(draw_go), 0);
    chk("busy_ack", 32'(busy), 1);
    chk("terr_ack", 32'(timeout_err), 0);
    draw_done = 1'b0; req = '0;
    @(negedge clock);
    chk("busy_idle", 32'(busy), 0);
    chk("ack_idle", 32'(ack), 0);
    chk("go_idle", 32'(draw_go), 0);
    last_g = w;
    n_draw++;
    $display("draw %0d: mask=%b grant=%0d line=%0d colour=%0d done_after=%0d",
             n_draw, mask, w, el, ec, dly);
  endtask

  initial begin
    int cyc;
    bit terr_seen;
    reset = 1'b1; req = '0; req_line_id = '0; req_colour = '0; draw_done = 1'b0;
    last_g = NREQ - 1;
    repeat (2) @(negedge clock);
    chk("rst_go", 32'(draw_go), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_line", 32'(draw_line_id), 0);
    chk("rst_colour", 32'(draw_colour), 0);
    chk("rst_grant", 32'(grant_id), NREQ - 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    reset = 1'b0;

    // Idle with no request: draw_done must be ignored.
    draw_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_go", 32'(draw_go), 0);
      chk("idle_busy_nr", 32'(busy), 0);
    end
    draw_done = 1'b0;

    // All requesting: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      run_draw(4'b1111, LIW'($urandom), CIW'($urandom), 2, 1'b0);
      chk("rr_order", 32'(last_g), k % NREQ);
    end

    // Single requester 2 with fixed data, done 10 cycles in.
    run_draw(4'b0100, 12'b000_011_000_000, 12'b000_100_000_000, 10, 1'b0);

    // Requester 1 joins mid-draw of 0 with new data; 1 wins next.
    run_draw(4'b0001, LIW'($urandom), CIW'($urandom), 4, 1'b1);
    run_draw(4'b0011, LIW'($urandom), CIW'($urandom), 1, 1'b0);

    // Reset during BUSY.
    req = 4'b0100; req_line_id = LIW'($urandom); req_colour = CIW'($urandom);
    @(negedge clock);
    chk("pre_rst_go", 32'(draw_go), 1);
    reset = 1'b1; req = '0;
    @(negedge clock);
    chk("midrst_go", 32'(draw_go), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_grant", 32'(grant_id), NREQ - 1);
    chk("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    last_g = NREQ - 1;
    run_draw(4'b0011, LIW'($urandom), CIW'($urandom), 0, 1'b0);
    chk("post_rst_first", 32'(last_g), 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_draw(m, LIW'($urandom), CIW'($urandom), $urandom_range(0, 6), 1'b1);
    end

    // Datapath never finishes.
    req = 4'b1000; req_line_id = LIW'($urandom); req_colour = CIW'($urandom);
    @(negedge clock);
    chk("stall_go", 32'(draw_go), 1);
    req = '0;
`ifdef DRAW_ARBITER_TIMEOUT_EN
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!draw_go) break;
      cyc++;
    end
    chk("wd_busy_cycles", 32'(cyc), TMO);
    chk("wd_ack", 32'(ack), 32'(4'b1000));
    chk("wd_terr", 32'(timeout_err), 1);
    @(negedge clock);
    chk("wd_terr_clear", 32'(timeout_err), 0);
    chk("wd_busy_idle", 32'(busy), 0);
    last_g = 3;
    $display("draw: watchdog abort after %0d busy cycles", cyc);
    // Done in the expiry cycle is a normal completion.
    run_draw(4'b0001, LIW'($urandom), CIW'($urandom), TMO - 1, 1'b0);
`else
    terr_seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (timeout_err) terr_seen = 1'b1;
      if (draw_go) cyc++;
    end
    chk("stall_go_cycles", 32'(cyc), 100);
    chk("stall_terr", 32'(terr_seen), 0);
    draw_done = 1'b1;
    @(negedge clock);
    chk("stall_ack", 32'(ack), 32'(4'b1000));
    draw_done = 1'b0;
    @(negedge clock);
    chk("stall_idle", 32'(busy), 0);
    last_g = 3;
    $display("draw: stalled draw held %0d cycles then completed", cyc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
